flow_feed_sched: RTL and testbench
==================================

FLOW_FEED_SCHED -- requirements
Module: flow_feed_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width.
REQ-002 SHALL have parameter SIZE_W, default 7, extended-block-size width.
REQ-003 SHALL have parameter ALPHA_W, default 3, fractional-phase width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  in  2  per-flow config request, bit f = flow f.
REQ-007 SHALL have port cfg_v_alpha, cfg_h_alpha  in  2xALPHA_W  per-flow vertical/horizontal phase.
REQ-008 SHALL have port cfg_ext_size  in  2xSIZE_W  per-flow extended size (SIZE+TAP-1).
REQ-009 SHALL have port cfg_ready  out  2  config accepted this cycle.
REQ-010 SHALL have port cfg_err  out  2  one-cycle pulse: config rejected.
REQ-011 SHALL have port px_valid  in  2  per-flow pixel available.
REQ-012 SHALL have port px_data  in  2xDATA_W  per-flow pixel.
REQ-013 SHALL have port px_ready  out  2  pixel consumed this cycle.
REQ-014 SHALL have ports v_alpha_din/h_alpha_din  out  ALPHA_W+1 each, {tag,value}; v_alpha_write/h_alpha_write  out  1.
REQ-015 SHALL have ports ext_size_din  out  SIZE_W+1, {tag,value}; ext_size_write  out  1.
REQ-016 SHALL have ports in_din  out  DATA_W+1, {tag,pixel}; in_write  out  1; in_full  in  2, per-flow downstream full.
REQ-017 SHALL have ports busy  out  2  flow configured/streaming; done  out  2  one-cycle pulse after last pixel written.

Function
REQ-018 Each flow SHALL run an FSM IDLE -> STREAM -> IDLE; cfg_ready[f]/px_ready[f] SHALL be combinational.
REQ-019 In IDLE, config SHALL be granted to at most one flow per cycle; on simultaneous cfg_valid, grant SHALL go to the flow not last configured (flow 0 after reset).
REQ-020 A granted config SHALL be legal only if ext_size in {11,15,23,39,71} and both alphas in {0,2,4,6}.
REQ-021 Legal granted config SHALL assert cfg_ready[f], register v/h/ext_size writes with tag f next cycle (all three write strobes together, one cycle), load remaining = ext_size^2 (13-bit), enter STREAM.
REQ-022 Illegal granted config SHALL assert cfg_ready[f] and cfg_err[f] same cycle, issue no writes, stay IDLE.
REQ-023 Flow f SHALL be pixel-eligible when STREAM, px_valid[f]=1, in_full[f]=0, remaining>0.
REQ-024 At most one pixel grant per cycle; if both eligible, grant SHALL alternate with the last-granted flow (round-robin); a sole eligible flow SHALL be granted every cycle.
REQ-025 Grant SHALL assert px_ready[f]; next cycle in_write=1, in_din={f,px_data[f]} (latency 1); otherwise in_write=0, in_din=0.
REQ-026 remaining SHALL decrement per grant; at transition to 0 the flow SHALL return to IDLE and pulse done[f] on the cycle its final in_write is visible.
REQ-027 Config of one flow and pixel streaming of the other SHALL proceed in the same cycle independently.
REQ-028 cfg_valid for a flow in STREAM SHALL be ignored (cfg_ready=0) until it returns to IDLE.
REQ-029 in_full[f] SHALL block only flow f; no pixel is dropped or duplicated under any full pattern.

Reset
REQ-030 rst=0 SHALL immediately clear all FSMs to IDLE, counters to 0, round-robin pointers to flow 0, and all outputs (writes, din, ready, err, busy, done) to 0, including mid-stream.
REQ-031 After rst release, the first rising edge SHALL be able to accept config.

Verification
REQ-032 Both cfg_valid same cycle, flow0 (6,4,39), flow1 (2,0,15) -> flow0 granted cycle N, writes {0,6},{0,4},{0,39} at N+1; flow1 granted N+1, writes {1,2},{1,0},{1,15} at N+2.
REQ-033 Both streaming, px_valid=11, in_full=00 -> in_write every cycle, tags 0,1,0,1...; after 225 flow1 pixels done[1] pulses, flow0 then every cycle until 1521 total, done[0].
REQ-034 in_full=01 for 5 cycles mid-stream -> only tag-1 writes in those cycles; flow0 count unchanged; total outputs still 1521/225.
REQ-035 cfg ext_size=16 or v_alpha=3 -> cfg_err pulse, no *_write, busy stays 0.
REQ-036 rst low after 100 flow0 pixels -> outputs 0 asynchronously; new config (0,0,11) then streams exactly 121 pixels, done[0].

Source files
------------

// File: rtl/flow_feed_sched_if.sv
// Handshake and bus bundle for flow_feed_sched: per-flow config and pixel inputs,
// tagged parameter/pixel writes toward the filter, and per-flow status.
interface flow_feed_sched_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SIZE_W  = 7,
  parameter int unsigned ALPHA_W = 3
);
  logic [1:0]           cfg_valid;
  logic [2*ALPHA_W-1:0] cfg_v_alpha;
  logic [2*ALPHA_W-1:0] cfg_h_alpha;
  logic [2*SIZE_W-1:0]  cfg_ext_size;
  logic [1:0]           cfg_ready;
  logic [1:0]           cfg_err;
  logic [1:0]           px_valid;
  logic [2*DATA_W-1:0]  px_data;
  logic [1:0]           px_ready;
  logic [ALPHA_W:0]     v_alpha_din;
  logic [ALPHA_W:0]     h_alpha_din;
  logic                 v_alpha_write;
  logic                 h_alpha_write;
  logic [SIZE_W:0]      ext_size_din;
  logic                 ext_size_write;
  logic [DATA_W:0]      in_din;
  logic                 in_write;
  logic [1:0]           in_full;
  logic [1:0]           busy;
  logic [1:0]           done;

  modport master (
    output cfg_valid, cfg_v_alpha, cfg_h_alpha, cfg_ext_size, px_valid, px_data, in_full,
    input  cfg_ready, cfg_err, px_ready, v_alpha_din, h_alpha_din, v_alpha_write,
           h_alpha_write, ext_size_din, ext_size_write, in_din, in_write, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_v_alpha, cfg_h_alpha, cfg_ext_size, px_valid, px_data, in_full,
    output cfg_ready, cfg_err, px_ready, v_alpha_din, h_alpha_din, v_alpha_write,
           h_alpha_write, ext_size_din, ext_size_write, in_din, in_write, busy, done
  );
endinterface

// File: rtl/flow_feed_sched.sv
// Two-flow feeder: validates per-flow block configuration, forwards it as tagged
// parameter writes, then interleaves each flow's ext_size^2 pixels into one tagged stream.
module flow_feed_sched #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SIZE_W  = 7,
  parameter int unsigned ALPHA_W = 3
) (
  input logic              clk,
  input logic              rst,
  flow_feed_sched_if.slave bus
);
  localparam int unsigned NF    = 2;
  localparam int unsigned REM_W = 13;
  localparam int unsigned SQ_W  = 2 * SIZE_W;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t             state     [NF];
  logic [REM_W-1:0]   remaining [NF];
  logic               cfg_pref;
  logic               px_pref;

  logic [NF-1:0]      cfg_cand;
  logic [NF-1:0]      px_elig;
  logic               cfg_go;
  logic               cfg_sel;
  logic               cfg_legal;
  logic               px_go;
  logic               px_sel;
  logic [ALPHA_W-1:0] sel_v;
  logic [ALPHA_W-1:0] sel_h;
  logic [SIZE_W-1:0]  sel_size;
  logic [REM_W-1:0]   sel_sq;
  logic [DATA_W-1:0]  sel_px;

  function automatic logic alpha_ok(input logic [ALPHA_W-1:0] a);
    return (a == ALPHA_W'(0)) || (a == ALPHA_W'(2)) ||
           (a == ALPHA_W'(4)) || (a == ALPHA_W'(6));
  endfunction

  function automatic logic size_ok(input logic [SIZE_W-1:0] s);
    return (s == SIZE_W'(11)) || (s == SIZE_W'(15)) || (s == SIZE_W'(23)) ||
           (s == SIZE_W'(39)) || (s == SIZE_W'(71));
  endfunction

  // Per-flow request masks; reset low forces every handshake off.
  always_comb begin
    for (int unsigned f = 0; f < NF; f++) begin
      cfg_cand[f] = rst && bus.cfg_valid[f] && (state[f] == IDLE);
      px_elig[f]  = rst && bus.px_valid[f] && !bus.in_full[f] &&
                    (state[f] == STREAM) && (remaining[f] != '0);
    end
  end

  // Arbitration: on contention the preferred flow wins, otherwise the sole requester.
  always_comb begin
    cfg_go    = |cfg_cand;
    cfg_sel   = (&cfg_cand) ? cfg_pref : cfg_cand[1];
    px_go     = |px_elig;
    px_sel    = (&px_elig) ? px_pref : px_elig[1];
    sel_v     = cfg_sel ? bus.cfg_v_alpha[2*ALPHA_W-1:ALPHA_W] : bus.cfg_v_alpha[ALPHA_W-1:0];
    sel_h     = cfg_sel ? bus.cfg_h_alpha[2*ALPHA_W-1:ALPHA_W] : bus.cfg_h_alpha[ALPHA_W-1:0];
    sel_size  = cfg_sel ? bus.cfg_ext_size[2*SIZE_W-1:SIZE_W] : bus.cfg_ext_size[SIZE_W-1:0];
    sel_sq    = REM_W'(SQ_W'(sel_size) * SQ_W'(sel_size));
    cfg_legal = size_ok(sel_size) && alpha_ok(sel_v) && alpha_ok(sel_h);
    sel_px    = px_sel ? bus.px_data[2*DATA_W-1:DATA_W] : bus.px_data[DATA_W-1:0];
  end

  always_comb begin
    bus.cfg_ready = '0;
    bus.cfg_err   = '0;
    bus.px_ready  = '0;
    if (cfg_go) begin
      bus.cfg_ready[cfg_sel] = 1'b1;
      bus.cfg_err[cfg_sel]   = !cfg_legal;
    end
    if (px_go) begin
      bus.px_ready[px_sel] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned f = 0; f < NF; f++) begin
      bus.busy[f] = (state[f] == STREAM);
    end
  end

  // Flow FSMs, counters, arbitration pointers and the registered write ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned f = 0; f < NF; f++) begin
        state[f]     <= IDLE;
        remaining[f] <= '0;
      end
      cfg_pref           <= 1'b0;
      px_pref            <= 1'b0;
      bus.v_alpha_din    <= '0;
      bus.h_alpha_din    <= '0;
      bus.ext_size_din   <= '0;
      bus.v_alpha_write  <= 1'b0;
      bus.h_alpha_write  <= 1'b0;
      bus.ext_size_write <= 1'b0;
      bus.in_din         <= '0;
      bus.in_write       <= 1'b0;
      bus.done           <= '0;
    end else begin
      bus.v_alpha_din    <= '0;
      bus.h_alpha_din    <= '0;
      bus.ext_size_din   <= '0;
      bus.v_alpha_write  <= 1'b0;
      bus.h_alpha_write  <= 1'b0;
      bus.ext_size_write <= 1'b0;
      bus.in_din         <= '0;
      bus.in_write       <= 1'b0;
      bus.done           <= '0;

      // Rejected configs still rotate the config preference.
      if (cfg_go) begin
        cfg_pref <= ~cfg_sel;
        if (cfg_legal) begin
          bus.v_alpha_din    <= {cfg_sel, sel_v};
          bus.h_alpha_din    <= {cfg_sel, sel_h};
          bus.ext_size_din   <= {cfg_sel, sel_size};
          bus.v_alpha_write  <= 1'b1;
          bus.h_alpha_write  <= 1'b1;
          bus.ext_size_write <= 1'b1;
          state[cfg_sel]     <= STREAM;
          remaining[cfg_sel] <= sel_sq;
        end
      end

      // A config grant and a pixel grant never target the same flow.
      if (px_go) begin
        px_pref           <= ~px_sel;
        bus.in_write      <= 1'b1;
        bus.in_din        <= {px_sel, sel_px};
        remaining[px_sel] <= remaining[px_sel] - REM_W'(1);
        if (remaining[px_sel] == REM_W'(1)) begin
          state[px_sel]    <= IDLE;
          bus.done[px_sel] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_flow_feed_sched.sv
// Scoreboard bench for flow_feed_sched: a per-cycle reference of the grant rules
// queues expected writes; an independent monitor checks them as they appear.
module tb_flow_feed_sched;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SIZE_W  = 7;
  localparam int unsigned ALPHA_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flow_feed_sched_if #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .ALPHA_W(ALPHA_W)) bus ();

  flow_feed_sched #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .ALPHA_W(ALPHA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; logic [DATA_W:0] din; } pix_t;
  typedef struct { int cyc; logic [ALPHA_W:0] v; logic [ALPHA_W:0] h; logic [SIZE_W:0] s; } cfg_t;
  typedef struct { int cyc; int tag; } done_t;

  pix_t  pix_q[$];
  cfg_t  cfg_q[$];
  done_t done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int out_cnt[2];

  // Reference state: streaming flag, pixels left, preferred flows, pending pixel values.
  bit                m_stream[2];
  int                m_rem[2];
  int                m_cfg_pref;
  int                m_px_pref;
  logic [DATA_W-1:0] pend[2];

  logic [1:0] s_cv, s_pv, s_full;
  int         s_va[2], s_ha[2], s_sz[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input int va, input int ha, input int sz);
    return (sz inside {11, 15, 23, 39, 71}) && (va inside {0, 2, 4, 6}) && (ha inside {0, 2, 4, 6});
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      m_stream[f] = 1'b0;
      m_rem[f]    = 0;
    end
    m_cfg_pref = 0;
    m_px_pref  = 0;
    pix_q.delete();
    cfg_q.delete();
    done_q.delete();
  endtask

  // One cycle: drive inputs at the falling edge, predict grants, check the handshakes.
  task automatic tick();
    logic [1:0] ecr, ece, epr;
    bit c0, c1, e0, e1;
    int cg, pg;
    @(negedge clk);
    bus.cfg_valid = s_cv;
    bus.px_valid  = s_pv;
    bus.in_full   = s_full;
    for (int f = 0; f < 2; f++) begin
      bus.cfg_v_alpha[f*ALPHA_W +: ALPHA_W]  = ALPHA_W'(s_va[f]);
      bus.cfg_h_alpha[f*ALPHA_W +: ALPHA_W]  = ALPHA_W'(s_ha[f]);
      bus.cfg_ext_size[f*SIZE_W +: SIZE_W]   = SIZE_W'(s_sz[f]);
      bus.px_data[f*DATA_W +: DATA_W]        = pend[f];
    end
    ecr = '0; ece = '0; epr = '0; cg = -1; pg = -1;
    if (!rst) begin
      model_reset();
    end else begin
      c0 = s_cv[0] && !m_stream[0];
      c1 = s_cv[1] && !m_stream[1];
      e0 = m_stream[0] && s_pv[0] && !s_full[0] && (m_rem[0] > 0);
      e1 = m_stream[1] && s_pv[1] && !s_full[1] && (m_rem[1] > 0);
      if (c0 && c1) cg = m_cfg_pref; else if (c0) cg = 0; else if (c1) cg = 1;
      if (e0 && e1) pg = m_px_pref;  else if (e0) pg = 0; else if (e1) pg = 1;
      if (cg >= 0) begin
        ecr[cg]    = 1'b1;
        m_cfg_pref = 1 - cg;
        if (legal(s_va[cg], s_ha[cg], s_sz[cg])) begin
          cfg_q.push_back('{cyc + 1, {cg[0], ALPHA_W'(s_va[cg])}, {cg[0], ALPHA_W'(s_ha[cg])},
                            {cg[0], SIZE_W'(s_sz[cg])}});
          m_stream[cg] = 1'b1;
          m_rem[cg]    = s_sz[cg] * s_sz[cg];
        end else begin
          ece[cg] = 1'b1;
        end
      end
      if (pg >= 0) begin
        epr[pg]   = 1'b1;
        m_px_pref = 1 - pg;
        pix_q.push_back('{cyc + 1, {pg[0], pend[pg]}});
        m_rem[pg]--;
        if (m_rem[pg] == 0) begin
          m_stream[pg] = 1'b0;
          done_q.push_back('{cyc + 1, pg});
        end
        pend[pg] = DATA_W'($urandom);
      end
    end
    #1;
    check("cfg_ready", bus.cfg_ready, ecr);
    check("cfg_err", bus.cfg_err, ece);
    check("px_ready", bus.px_ready, epr);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    s_cv = '0; s_pv = 2'b11; s_full = '0;
    while ((m_stream[0] || m_stream[1]) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, budget);
    end
    s_pv = '0;
    repeat (3) tick();
  endtask

  // Monitor: registered outputs checked just after each rising edge.
  initial begin
    logic    exp_w, exp_c;
    logic [1:0] exp_d;
    pix_t    p;
    cfg_t    c;
    forever begin
      @(posedge clk);
      #1;
      exp_w = (pix_q.size() > 0) && (pix_q[0].cyc == cyc);
      check("in_write", bus.in_write, exp_w);
      if (exp_w) begin
        p = pix_q.pop_front();
        check("in_din", bus.in_din, p.din);
      end else begin
        check("in_din_idle", bus.in_din, 0);
      end
      if (bus.in_write) out_cnt[bus.in_din[DATA_W]]++;
      exp_c = (cfg_q.size() > 0) && (cfg_q[0].cyc == cyc);
      check("cfg_writes", {bus.v_alpha_write, bus.h_alpha_write, bus.ext_size_write}, {3{exp_c}});
      if (exp_c) begin
        c = cfg_q.pop_front();
        check("v_alpha_din", bus.v_alpha_din, c.v);
        check("h_alpha_din", bus.h_alpha_din, c.h);
        check("ext_size_din", bus.ext_size_din, c.s);
      end
      exp_d = '0;
      while (done_q.size() > 0 && done_q[0].cyc == cyc) exp_d[done_q.pop_front().tag] = 1'b1;
      check("done", bus.done, exp_d);
      check("busy", bus.busy, {m_stream[1], m_stream[0]});
    end
  end

  initial begin
    bus.cfg_valid = '0; bus.cfg_v_alpha = '0; bus.cfg_h_alpha = '0; bus.cfg_ext_size = '0;
    bus.px_valid = '0; bus.px_data = '0; bus.in_full = '0;
    s_cv = '0; s_pv = '0; s_full = '0;
    s_va = '{0, 0}; s_ha = '{0, 0}; s_sz = '{0, 0};
    out_cnt = '{0, 0};
    for (int f = 0; f < 2; f++) pend[f] = DATA_W'($urandom);
    model_reset();

    // Reset state with a config request pending.
    bus.cfg_valid = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_outputs", {bus.in_write, bus.v_alpha_write, bus.busy, bus.done}, 0);
    bus.cfg_valid = '0;
    rst = 1'b1;

    // Simultaneous configs, then both flows streaming with a flow-0 full burst.
    s_cv = 2'b11; s_va = '{6, 2}; s_ha = '{4, 0}; s_sz = '{39, 15};
    tick();
    tick();
    s_cv = 2'b01;
    tick();
    s_cv = '0; s_pv = 2'b11;
    repeat (300) tick();
    s_full = 2'b01;
    repeat (5) tick();
    s_full = '0;
    drain(4000);
    check("flow0_pixels", out_cnt[0], 1521);
    check("flow1_pixels", out_cnt[1], 225);

    // Rejected configs: bad size on flow 0, odd alpha on flow 1.
    s_pv = '0;
    s_cv = 2'b01; s_va[0] = 0; s_ha[0] = 0; s_sz[0] = 16;
    tick();
    s_cv = 2'b10; s_va[1] = 3; s_ha[1] = 2; s_sz[1] = 11;
    tick();
    s_cv = '0;
    repeat (2) tick();
    check("busy_after_illegal", bus.busy, 0);

    // Random configs, valids and full patterns.
    for (int i = 0; i < 3000; i++) begin
      s_cv   = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      s_pv   = 2'($urandom);
      s_full = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      for (int f = 0; f < 2; f++) begin
        s_va[f] = 2 * $urandom_range(0, 3);
        s_ha[f] = 2 * $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0: s_sz[f] = 11;
          1: s_sz[f] = 15;
          2: s_sz[f] = 23;
          default: s_sz[f] = 11;
        endcase
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 1) == 0) s_sz[f] = 16; else s_ha[f] = 5;
        end
      end
      tick();
    end
    drain(20000);

    // Asynchronous reset mid-stream, then a fresh short block.
    out_cnt = '{0, 0};
    s_cv = 2'b01; s_va[0] = 0; s_ha[0] = 0; s_sz[0] = 39; s_pv = '0;
    tick();
    s_cv = '0; s_pv = 2'b01;
    repeat (100) tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("pixels_before_rst", out_cnt[0], 100);
    check("async_rst_writes", {bus.in_write, bus.v_alpha_write, bus.h_alpha_write, bus.ext_size_write}, 0);
    check("async_rst_din", bus.in_din, 0);
    check("async_rst_busy_done", {bus.busy, bus.done}, 0);
    check("async_rst_ready", {bus.px_ready, bus.cfg_ready, bus.cfg_err}, 0);
    repeat (2) tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    out_cnt = '{0, 0};
    s_cv = 2'b01; s_va[0] = 0; s_ha[0] = 0; s_sz[0] = 11; s_pv = 2'b01;
    tick();
    drain(1000);
    check("post_rst_flow0_pixels", out_cnt[0], 121);
    check("post_rst_flow1_pixels", out_cnt[1], 0);
    check("queues_empty", pix_q.size() + cfg_q.size() + done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
